// File: rtl/axi_line_write.sv
// AXI4 write master: writes one image line (TRANSACTION_NUM INCR bursts of BURST_LEN beats) per wr_en.
// Define AXI_WR_ERR_CNT_EN to enable the saturating bresp error counter on err_cnt.

module axi_line_write #(
  parameter int ADDR_W          = 29,
  parameter int BURST_LEN       = 240,
  parameter int TRANSACTION_NUM = 2,
  parameter int ADDR_STEP       = 960,
  parameter int BASE_ADDR       = 0
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              frame_start,
  input  logic [31:0]       din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              axi_awid,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic [7:0]        axi_awlen,
  output logic [2:0]        axi_awsize,
  output logic [1:0]        axi_awburst,
  output logic [3:0]        axi_awcache,
  output logic [2:0]        axi_awprot,
  output logic [3:0]        axi_awqos,
  output logic              axi_awlock,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [31:0]       axi_wdata,
  output logic [3:0]        axi_wstrb,
  output logic              axi_wlast,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  input  logic [1:0]        axi_bresp,
  input  logic              axi_bvalid,
  output logic              axi_bready,
  output logic              busy,
  output logic              wr_done,
  output logic [7:0]        err_cnt
);

  localparam int BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BURST_W = (TRANSACTION_NUM > 1) ? $clog2(TRANSACTION_NUM) : 1;
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(TRANSACTION_NUM - 1);
  localparam logic [ADDR_W-1:0]  BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]  STEP       = ADDR_W'(ADDR_STEP);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [BURST_W-1:0]  burst_cnt;
  logic [ADDR_W-1:0]   addr_reg;
  logic                fs_pend;
  logic                aw_hs;
  logic                w_hs;
  logic                b_hs;
  logic                last_beat;

  assign aw_hs     = (state == S_AW) && axi_awready;
  assign w_hs      = (state == S_W) && din_valid && axi_wready;
  assign b_hs      = (state == S_B) && axi_bvalid;
  assign last_beat = (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (wr_en) state_next = S_AW;
        else       state_next = S_IDLE;
      end
      S_AW: begin
        if (axi_awready) state_next = S_W;
        else             state_next = S_AW;
      end
      S_W: begin
        if (w_hs && last_beat) state_next = S_B;
        else                   state_next = S_W;
      end
      S_B: begin
        if (!axi_bvalid)                   state_next = S_B;
        else if (burst_cnt == LAST_BURST)  state_next = S_DONE;
        else                               state_next = S_AW;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      beat_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      if ((state == S_IDLE) && wr_en) begin
        beat_cnt  <= '0;
        burst_cnt <= '0;
      end
      if (w_hs) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      if (b_hs) burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // A frame_start seen mid-line is held and applied as the line returns to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      addr_reg <= BASE;
      fs_pend  <= 1'b0;
    end else if (state == S_IDLE) begin
      fs_pend <= 1'b0;
      if (frame_start) addr_reg <= BASE;
    end else if (state == S_DONE) begin
      fs_pend <= 1'b0;
      if (frame_start || fs_pend) addr_reg <= BASE;
    end else begin
      if (frame_start) fs_pend <= 1'b1;
      if (aw_hs)       addr_reg <= addr_reg + STEP;
    end
  end

  assign axi_awid    = 1'b0;
  assign axi_awprot  = 3'b000;
  assign axi_awqos   = 4'b0000;
  assign axi_awlock  = 1'b0;
  assign axi_awvalid = (state == S_AW);
  assign axi_awaddr  = (state == S_IDLE) ? '0 : addr_reg;
  assign axi_awlen   = (state == S_IDLE) ? 8'd0 : 8'(BURST_LEN - 1);
  assign axi_awsize  = (state == S_IDLE) ? 3'b000 : 3'b010;
  assign axi_awburst = (state == S_IDLE) ? 2'b00 : 2'b01;
  assign axi_awcache = (state == S_IDLE) ? 4'b0000 : 4'b0011;

  // The W channel is a direct pass-through of the pixel stream so no beat is ever buffered.
  assign axi_wdata  = din;
  assign axi_wstrb  = 4'hF;
  assign axi_wvalid = (state == S_W) && din_valid;
  assign axi_wlast  = (state == S_W) && last_beat;
  assign din_ready  = (state == S_W) && axi_wready;
  assign axi_bready = (state == S_B);
  assign busy       = (state != S_IDLE);
  assign wr_done    = (state == S_DONE);

`ifdef AXI_WR_ERR_CNT_EN
  logic [7:0] err_cnt_r;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      err_cnt_r <= 8'd0;
    end else if (b_hs && (axi_bresp != 2'b00) && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  logic unused_bresp;
  assign unused_bresp = ^axi_bresp;
  assign err_cnt      = 8'd0;
`endif

endmodule

// File: tb/tb_axi_line_write.sv
// Randomized self-checking bench for axi_line_write against a transaction-level line model.
// Build with AXI_WR_ERR_CNT_EN defined to expect the bresp error counter.

module tb_axi_line_write;

  localparam int ADDR_W = 29;
  localparam int BL     = 240;
  localparam int TN     = 2;
  localparam int STEP   = 960;
  localparam int NPIN   = 23;
`ifdef AXI_WR_ERR_CNT_EN
  localparam int EXP_ERR = 2;
`else
  localparam int EXP_ERR = 0;
`endif

  logic              clk_i       = 1'b0;
  logic              rst         = 1'b1;
  logic              wr_en       = 1'b0;
  logic              frame_start = 1'b0;
  logic [31:0]       din         = 32'd0;
  logic              din_valid   = 1'b0;
  logic              din_ready;
  logic              axi_awid;
  logic [ADDR_W-1:0] axi_awaddr;
  logic [7:0]        axi_awlen;
  logic [2:0]        axi_awsize;
  logic [1:0]        axi_awburst;
  logic [3:0]        axi_awcache;
  logic [2:0]        axi_awprot;
  logic [3:0]        axi_awqos;
  logic              axi_awlock;
  logic              axi_awvalid;
  logic              axi_awready = 1'b0;
  logic [31:0]       axi_wdata;
  logic [3:0]        axi_wstrb;
  logic              axi_wlast;
  logic              axi_wvalid;
  logic              axi_wready  = 1'b0;
  logic [1:0]        axi_bresp   = 2'b00;
  logic              axi_bvalid  = 1'b0;
  logic              axi_bready;
  logic              busy;
  logic              wr_done;
  logic [7:0]        err_cnt;

  axi_line_write #(
    .ADDR_W(ADDR_W), .BURST_LEN(BL), .TRANSACTION_NUM(TN), .ADDR_STEP(STEP), .BASE_ADDR(0)
  ) dut (
    .clk_i(clk_i), .rst(rst), .wr_en(wr_en), .frame_start(frame_start),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awcache(axi_awcache),
    .axi_awprot(axi_awprot), .axi_awqos(axi_awqos), .axi_awlock(axi_awlock),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .busy(busy), .wr_done(wr_done), .err_cnt(err_cnt)
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Stimulus controls (written by the sequencer only)
  int         mode      = 0;
  logic [1:0] bresp_val = 2'b00;
  bit         stall_en  = 1'b0;

  // Slave / source state (written by the driver only)
  int unsigned pix       = 0;
  int          bpend     = 0;
  int          cyc       = 0;
  int          stall_cnt = 0;
  logic        drv_rst;

  // Handshakes observed on the last falling edge (written by the compare process only)
  bit hs_din = 1'b0, hs_wlast = 1'b0, hs_b = 1'b0;

  always @(posedge clk_i) begin
    drv_rst = rst;
    #1;
    cyc++;
    if (drv_rst) begin
      pix   = 0;
      bpend = 0;
    end else begin
      if (hs_din) pix++;
      if (hs_wlast) bpend++;
      if (hs_b && bpend > 0) bpend--;
    end
    din = pix;
    if (mode == 2) begin
      din_valid   = ($urandom_range(0, 3) != 0);
      axi_wready  = ($urandom_range(0, 3) != 0);
      axi_awready = ($urandom_range(0, 1) == 1);
      axi_bvalid  = (bpend > 0) && ($urandom_range(0, 1) == 1);
      axi_bresp   = 2'($urandom_range(0, 3));
    end else begin
      din_valid   = (mode == 1) ? ~din_valid : 1'b1;
      axi_wready  = (mode == 1) ? ((cyc % 16) >= 3) : 1'b1;
      axi_awready = 1'b1;
      axi_bvalid  = (bpend > 0);
      axi_bresp   = bresp_val;
    end
    if (!stall_en) begin
      stall_cnt = 0;
    end else if (axi_awvalid && stall_cnt < 10) begin
      axi_awready = 1'b0;
      stall_cnt++;
    end
  end

  // Line-level model: next burst address, pending frame restart, expected beat stream
  int          m_addr = 0;
  bit          m_busy, m_aw_exp, m_in_w, m_in_b, m_pend, m_done_exp, post_rst;
  int          m_beat, m_burst, m_line_beats, m_err, wd;
  int          aw_idx = 0;
  int unsigned m_exp_pix;
  bit          prev_aw_wait;
  logic [ADDR_W-1:0] prev_awaddr;
  bit          busy_now, done_now, aw_hs, w_hs, b_hs;
  int pin_addr [NPIN] = '{0, 960, 1920, 2880, 3840, 4800, 0, 960, 0, 960, 1920, 2880,
                          3840, 4800, 5760, 6720, 0, 960, 1920, 0, 960, 1920, 2880};

  always @(negedge clk_i) begin
    if (rst) begin
      m_addr = 0; m_busy = 0; m_aw_exp = 0; m_in_w = 0; m_in_b = 0; m_pend = 0;
      m_done_exp = 0; m_beat = 0; m_burst = 0; m_line_beats = 0; m_err = 0; wd = 0;
      m_exp_pix = 0; prev_aw_wait = 0; post_rst = 1;
      hs_din = 0; hs_wlast = 0; hs_b = 0;
    end else begin
      busy_now = m_busy;
      done_now = m_done_exp;
      if (post_rst) begin
        chk("post_reset_outputs", 64'({axi_awvalid, axi_wvalid, axi_wlast, axi_bready,
                                        din_ready, busy, wr_done}), 64'd0);
        chk("post_reset_err_cnt", 64'(err_cnt), 64'd0);
        post_rst = 0;
      end
      chk("busy", 64'(busy), 64'(m_busy));
      chk("wr_done", 64'(wr_done), 64'(m_done_exp));
      chk("awvalid", 64'(axi_awvalid), 64'(m_aw_exp));
      chk("din_ready", 64'(din_ready), 64'(m_in_w && axi_wready));
      chk("wvalid", 64'(axi_wvalid), 64'(m_in_w && din_valid));
      chk("bready", 64'(axi_bready), 64'(m_in_b));
      chk("err_cnt", 64'(err_cnt), 64'(m_err));
      if (!busy_now)
        chk("idle_aw_fields", 64'({axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awcache}), 64'd0);
      if (prev_aw_wait) chk("awaddr_stable", 64'(axi_awaddr), 64'(prev_awaddr));

      aw_hs = m_aw_exp && axi_awready;
      w_hs  = m_in_w && din_valid && axi_wready;
      b_hs  = m_in_b && axi_bvalid;
      prev_aw_wait = m_aw_exp && !axi_awready;
      prev_awaddr  = axi_awaddr;
      hs_din   = din_valid && din_ready;
      hs_wlast = axi_wvalid && axi_wready && axi_wlast;
      hs_b     = axi_bvalid && axi_bready;
      m_done_exp = 0;

      if (aw_hs) begin
        chk("awaddr", 64'(axi_awaddr), 64'(m_addr));
        chk("aw_constants", 64'({axi_awid, axi_awlen, axi_awsize, axi_awburst, axi_awcache,
                                 axi_awprot, axi_awqos, axi_awlock, axi_wstrb}),
            64'({1'b0, 8'd239, 3'b010, 2'b01, 4'b0011, 3'b000, 4'b0000, 1'b0, 4'hF}));
        if (aw_idx < NPIN) chk("pinned_awaddr", 64'(axi_awaddr), 64'(pin_addr[aw_idx]));
        aw_idx++;
        m_addr   = (m_addr + STEP) % (1 << ADDR_W);
        m_aw_exp = 0;
        m_in_w   = 1;
      end
      if (w_hs) begin
        chk("wdata", 64'(axi_wdata), 64'(m_exp_pix));
        chk("wlast", 64'(axi_wlast), 64'(m_beat == BL - 1));
        m_exp_pix++;
        m_line_beats++;
        if (m_beat == BL - 1) begin
          m_beat = 0; m_in_w = 0; m_in_b = 1;
        end else begin
          m_beat++;
        end
      end
      if (b_hs) begin
        m_in_b = 0;
        m_burst++;
`ifdef AXI_WR_ERR_CNT_EN
        if (axi_bresp != 2'b00 && m_err < 255) m_err++;
`endif
        if (m_burst == TN) m_done_exp = 1;
        else               m_aw_exp = 1;
      end
      if (done_now) begin
        chk("line_beats", 64'(m_line_beats), 64'd480);
        if (mode == 0 && bresp_val == 2'b10) chk("err_cnt_bresp_err", 64'(err_cnt), 64'(EXP_ERR));
        if (m_pend || frame_start) m_addr = 0;
        m_pend = 0;
        m_busy = 0;
        m_line_beats = 0;
      end else if (frame_start) begin
        if (!busy_now) m_addr = 0;
        else           m_pend = 1;
      end
      if (!busy_now && wr_en) begin
        m_busy = 1; m_aw_exp = 1; m_burst = 0; m_beat = 0;
      end
      if (busy_now) wd++;
      else          wd = 0;
      if (wd == 5000) begin
        n_total++;
        $display("FAIL watchdog: busy for %0d cycles, limit 5000", wd);
      end
    end
  end

  task automatic pulse_wr(input bit fs, input int len);
    @(posedge clk_i); #1;
    wr_en = 1'b1; frame_start = fs;
    @(posedge clk_i); #1;
    frame_start = 1'b0;
    for (int i = 1; i < len; i++) begin
      @(posedge clk_i); #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk_i);
      if (wr_done) break;
    end
  endtask

  task automatic line(input bit fs);
    pulse_wr(fs, 1);
    wait_done();
  endtask

  task automatic fs_pulse();
    @(posedge clk_i); #1; frame_start = 1'b1;
    @(posedge clk_i); #1; frame_start = 1'b0;
  endtask

  int unsigned p0;

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst = 1'b0;
    line(1'b0); line(1'b0); line(1'b0);          // 0/960, 1920/2880, 3840/4800
    fs_pulse(); line(1'b0);                      // restart in IDLE -> 0/960
    line(1'b1);                                  // frame_start with wr_en -> 0/960
    mode = 1; line(1'b0); mode = 0;              // stalled stream -> 1920/2880
    stall_en = 1'b1; line(1'b0); stall_en = 1'b0; // awready low 10 cycles -> 3840/4800
    pulse_wr(1'b0, 1);                           // 5760/6720 with mid-line restart
    repeat (300) @(posedge clk_i);
    #1 frame_start = 1'b1; wr_en = 1'b1;
    @(posedge clk_i); #1 frame_start = 1'b0; wr_en = 1'b0;
    wait_done();
    line(1'b0);                                  // 0/960
    p0 = pix;                                    // reset on beat 100 of burst 0 at 1920
    pulse_wr(1'b0, 1);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_i); #2;
      if (pix - p0 == 100) break;
    end
    rst = 1'b1;
    @(posedge clk_i); #1 rst = 1'b0;
    repeat (3) @(posedge clk_i);
    line(1'b0);                                  // 0/960
    bresp_val = 2'b10; line(1'b0); bresp_val = 2'b00; // 1920/2880 with error responses
    mode = 2;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 2) == 0) fs_pulse();
      pulse_wr($urandom_range(0, 3) == 0, $urandom_range(1, 3));
      repeat ($urandom_range(10, 400)) @(posedge clk_i);
      #1 frame_start = ($urandom_range(0, 1) == 1);
      @(posedge clk_i); #1 frame_start = 1'b0;
      wait_done();
    end
    repeat (5) @(posedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_line_write.md
Name: axi_line_write

Overview:
- AXI4 write master that stores one image line (BURST_LEN × TRANSACTION_NUM 32-bit beats) into DDR per wr_en request.
- Input comes from the UDP receive pixel buffer through a valid/ready stream.
- Issues TRANSACTION_NUM sequential INCR bursts (AW → W → B) and advances a line address register.
- Write-side counterpart of the frame-buffer line reader that feeds HDMI.

Parameters:
- ADDR_W, 29, AXI address width.
- BURST_LEN, 240, beats per burst (awlen = BURST_LEN-1).
- TRANSACTION_NUM, 2, bursts per line.
- ADDR_STEP, 960, byte address increment per burst (BURST_LEN × 4).
- BASE_ADDR, 0, first byte address of a frame.

Ports:
- clk_i  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  start one line write (pulse or level; sampled only in IDLE)
- frame_start  in  1  reset line address to BASE_ADDR
- din  in  32  pixel word
- din_valid  in  1  din valid
- din_ready  out  1  din accepted this cycle
- axi_awid  out  1  always 0
- axi_awaddr  out  ADDR_W  burst address
- axi_awlen  out  8  BURST_LEN-1
- axi_awsize  out  3  3'b010
- axi_awburst  out  2  2'b01
- axi_awcache  out  4  4'b0011
- axi_awprot  out  3  0
- axi_awqos  out  4  0
- axi_awlock  out  1  0
- axi_awvalid  out  1  AW valid
- axi_awready  in  1  AW ready
- axi_wdata  out  32  = din
- axi_wstrb  out  4  4'hF
- axi_wlast  out  1  last beat of burst
- axi_wvalid  out  1  W valid
- axi_wready  in  1  W ready
- axi_bresp  in  2  write response
- axi_bvalid  in  1  B valid
- axi_bready  out  1  B ready
- busy  out  1  state != IDLE
- wr_done  out  1  one-cycle pulse, line complete
- err_cnt  out  8  bresp error count (see Optional Feature)

Behaviour:
- States: IDLE, AW, W, B, DONE.
- IDLE → AW when wr_en = 1; clears burst_cnt and beat_cnt.
- AW: axi_awvalid = 1, held until axi_awready; awaddr = addr_reg, stable while awvalid is high. On handshake → W, and addr_reg += ADDR_STEP (ADDR_W-bit wrap).
- W: axi_wvalid = din_valid; din_ready = axi_wready (combinational, W state only, else 0).
  - beat_cnt increments on each wvalid && wready.
  - axi_wlast = (beat_cnt == BURST_LEN-1).
  - Handshake with wlast → B.
  - Data is never dropped or duplicated; din stalls are legal.
- B: axi_bready = 1. On bvalid: burst_cnt++; if burst_cnt == TRANSACTION_NUM-1 → DONE, else → AW.
- DONE: wr_done = 1 for exactly one cycle → IDLE.
- frame_start:
  - In IDLE: addr_reg ← BASE_ADDR next cycle, priority over wr_en's address use.
  - Otherwise latched as pending and applied on entry to IDLE.
- wr_en outside IDLE is ignored, not queued.
- Simultaneous frame_start and wr_en in IDLE: address resets first; the AW issued the following cycle uses BASE_ADDR.
- Reset (any state, mid-burst included):
  - State → IDLE; awvalid, wvalid, wlast, bready, din_ready, busy, wr_done = 0.
  - addr_reg = BASE_ADDR; pending frame_start cleared; err_cnt = 0.
  - Awaddr/len/size/burst/cache = 0 in IDLE, constants otherwise.
  - Reset must coincide with interconnect reset.
- Latency: wr_en → awvalid 1 cycle. Last bvalid → wr_done 1 cycle.

Optional Feature:
- Macro AXI_WR_ERR_CNT_EN.
- Defined: err_cnt increments on each bvalid && bready with bresp != 2'b00; saturates at 255; cleared only by rst.
- Not defined: err_cnt tied to 0, no counter logic.
- All other behaviour is identical either way.

Test Plan:
- Reset, wr_en pulse, awready/wready/bvalid always 1, din always valid → two AW at 0 and 960, 240 beats each, wlast on beats 239 and 479, wr_done 1 cycle after second bvalid.
- Three lines back to back without frame_start, then a frame_start in IDLE and a fourth line → awaddr 0, 960, 1920, 2880, 3840, 4800, then 0.
- din_valid toggling 1/0 and wready low 3 cycles every 16 → exactly 480 beats accepted in order (ramp 0..479 checked), no extra din_ready pulses.
- awready held low 10 cycles → awvalid and awaddr stable for all 10 cycles; frame_start mid-line → current line completes at old addresses, next line starts at 0.
- rst asserted on beat 100 of burst 0 → all valids 0 next cycle, busy 0; next wr_en starts at address 0.
- With AXI_WR_ERR_CNT_EN, bresp = 2'b10 on both bursts → err_cnt = 2; without the macro → err_cnt = 0.
